// File: rtl/function_eval_driver_if.sv
// ============================================================================
// Module   : function_eval_driver_if
// Brief    : Command/operand bus between the driver and a function evaluator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

interface function_eval_driver_if #(
    parameter int FLT_DATA_WIDTH = 32,
    parameter int N_WIDTH        = 2
);
    logic                      ci_clk_en;
    logic                      ci_start;
    logic [N_WIDTH-1:0]        ci_n;
    logic [FLT_DATA_WIDTH-1:0] ci_x_one;
    logic [FLT_DATA_WIDTH-1:0] ci_x_two;
    logic [FLT_DATA_WIDTH-1:0] ci_x_three;
    logic                      ci_done;
    logic [FLT_DATA_WIDTH-1:0] ci_result;

    modport master (
        output ci_clk_en, ci_start, ci_n, ci_x_one, ci_x_two, ci_x_three,
        input  ci_done, ci_result
    );

    modport slave (
        input  ci_clk_en, ci_start, ci_n, ci_x_one, ci_x_two, ci_x_three,
        output ci_done, ci_result
    );
endinterface

`default_nettype wire

// File: rtl/function_eval_driver.sv
// ============================================================================
// Module   : function_eval_driver
// Brief    : Groups a float sample stream into operand triples and sequences
//            CLEAR / GO... / READ commands to an evaluator, with timeout.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module function_eval_driver #(
    parameter int                 FLT_DATA_WIDTH = 32,
    parameter int                 N_WIDTH        = 2,
    parameter int                 TIMEOUT_CYCLES = 1024,
    parameter logic [N_WIDTH-1:0] CLEAR          = N_WIDTH'(0),
    parameter logic [N_WIDTH-1:0] GO             = N_WIDTH'(1),
    parameter logic [N_WIDTH-1:0] READ           = N_WIDTH'(2)
) (
    input  wire logic                      clk,
    input  wire logic                      rst,
    input  wire logic                      job_start,
    input  wire logic                      s_valid,
    input  wire logic [FLT_DATA_WIDTH-1:0] s_data,
    input  wire logic                      s_last,
    output logic                           s_ready,
    function_eval_driver_if.master         ci,
    output logic                           job_done,
    output logic [FLT_DATA_WIDTH-1:0]      job_result,
    output logic                           job_error,
    output logic [15:0]                    triple_count
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_CLR_ISSUE = 4'd1;
    localparam logic [3:0] ST_CLR_WAIT  = 4'd2;
    localparam logic [3:0] ST_FILL      = 4'd3;
    localparam logic [3:0] ST_GO_ISSUE  = 4'd4;
    localparam logic [3:0] ST_GO_WAIT   = 4'd5;
    localparam logic [3:0] ST_RD_ISSUE  = 4'd6;
    localparam logic [3:0] ST_RD_WAIT   = 4'd7;
    localparam logic [3:0] ST_FINISH    = 4'd8;

    localparam logic [15:0] TIMEOUT_W = 16'(TIMEOUT_CYCLES);
    localparam logic [FLT_DATA_WIDTH-1:0] ZERO = '0;

    logic [3:0]                state_q, state_d;
    logic [N_WIDTH-1:0]        ci_n_q, ci_n_d;
    logic [FLT_DATA_WIDTH-1:0] x_one_q, x_one_d, x_two_q, x_two_d, x_three_q, x_three_d;
    logic [1:0]                fill_idx_q, fill_idx_d;
    logic                      last_q, last_d;
    logic [15:0]               triple_count_q, triple_count_d;
    logic [15:0]               wait_cnt_q, wait_cnt_d;
    logic [FLT_DATA_WIDTH-1:0] job_result_q, job_result_d;
    logic                      job_error_q, job_error_d;
    logic [15:0]               wait_inc;
    logic                      timeout_hit;
    logic                      s_ready_c, ci_start_c, ci_clk_en_c, job_done_c;

    assign wait_inc    = wait_cnt_q + 16'd1;
    assign timeout_hit = (wait_inc == TIMEOUT_W);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ci_done has priority over the timeout so a completion on the last
    // allowed cycle is never reported as an error.
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:      if (job_start) state_d = ST_CLR_ISSUE;
            ST_CLR_ISSUE: state_d = ST_CLR_WAIT;
            ST_CLR_WAIT: begin
                if (ci.ci_done)       state_d = ST_FILL;
                else if (timeout_hit) state_d = ST_FINISH;
            end
            ST_FILL: begin
                if (s_valid && ((fill_idx_q == 2'd2) || s_last)) state_d = ST_GO_ISSUE;
            end
            ST_GO_ISSUE:  state_d = ST_GO_WAIT;
            ST_GO_WAIT: begin
                if (ci.ci_done)       state_d = last_q ? ST_RD_ISSUE : ST_FILL;
                else if (timeout_hit) state_d = ST_FINISH;
            end
            ST_RD_ISSUE:  state_d = ST_RD_WAIT;
            ST_RD_WAIT: begin
                if (ci.ci_done || timeout_hit) state_d = ST_FINISH;
            end
            ST_FINISH:    state_d = ST_IDLE;
            default:      state_d = ST_IDLE;
        endcase
    end

    always_comb begin
        s_ready_c   = (state_q == ST_FILL);
        ci_start_c  = (state_q == ST_CLR_ISSUE) || (state_q == ST_GO_ISSUE) ||
                      (state_q == ST_RD_ISSUE);
        ci_clk_en_c = (state_q != ST_IDLE);
        job_done_c  = (state_q == ST_FINISH);
    end

    always_comb begin
        ci_n_d         = ci_n_q;
        x_one_d        = x_one_q;
        x_two_d        = x_two_q;
        x_three_d      = x_three_q;
        fill_idx_d     = fill_idx_q;
        last_d         = last_q;
        triple_count_d = triple_count_q;
        wait_cnt_d     = wait_cnt_q;
        job_result_d   = job_result_q;
        job_error_d    = job_error_q;

        // The command code is latched on ISSUE entry and held through WAIT.
        case (state_d)
            ST_CLR_ISSUE: ci_n_d = CLEAR;
            ST_GO_ISSUE:  ci_n_d = GO;
            ST_RD_ISSUE:  ci_n_d = READ;
            default:      ci_n_d = ci_n_q;
        endcase

        case (state_q)
            ST_IDLE: begin
                if (job_start) job_error_d = 1'b0;
            end
            ST_CLR_ISSUE, ST_GO_ISSUE, ST_RD_ISSUE: begin
                wait_cnt_d = 16'd0;
            end
            ST_CLR_WAIT, ST_GO_WAIT, ST_RD_WAIT: begin
                wait_cnt_d = wait_inc;
                if (ci.ci_done) begin
                    if (state_q == ST_RD_WAIT) begin
                        job_result_d = ci.ci_result;
                    end else begin
                        if (state_q == ST_CLR_WAIT) begin
                            triple_count_d = 16'd0;
                        end else if (triple_count_q != 16'hFFFF) begin
                            triple_count_d = triple_count_q + 16'd1;
                        end
                        if ((state_q == ST_CLR_WAIT) || !last_q) begin
                            x_one_d    = ZERO;
                            x_two_d    = ZERO;
                            x_three_d  = ZERO;
                            fill_idx_d = 2'd0;
                            last_d     = 1'b0;
                        end
                    end
                end else if (timeout_hit) begin
                    job_error_d = 1'b1;
                end
            end
            ST_FILL: begin
                if (s_valid) begin
                    case (fill_idx_q)
                        2'd0:    x_one_d   = s_data;
                        2'd1:    x_two_d   = s_data;
                        default: x_three_d = s_data;
                    endcase
                    fill_idx_d = fill_idx_q + 2'd1;
                    last_d     = s_last;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ci_n_q         <= CLEAR;
            x_one_q        <= '0;
            x_two_q        <= '0;
            x_three_q      <= '0;
            fill_idx_q     <= 2'd0;
            last_q         <= 1'b0;
            triple_count_q <= 16'd0;
            wait_cnt_q     <= 16'd0;
            job_result_q   <= '0;
            job_error_q    <= 1'b0;
        end else begin
            ci_n_q         <= ci_n_d;
            x_one_q        <= x_one_d;
            x_two_q        <= x_two_d;
            x_three_q      <= x_three_d;
            fill_idx_q     <= fill_idx_d;
            last_q         <= last_d;
            triple_count_q <= triple_count_d;
            wait_cnt_q     <= wait_cnt_d;
            job_result_q   <= job_result_d;
            job_error_q    <= job_error_d;
        end
    end

    assign s_ready       = s_ready_c;
    assign ci.ci_start   = ci_start_c;
    assign ci.ci_clk_en  = ci_clk_en_c;
    assign ci.ci_n       = ci_n_q;
    assign ci.ci_x_one   = x_one_q;
    assign ci.ci_x_two   = x_two_q;
    assign ci.ci_x_three = x_three_q;
    assign job_done      = job_done_c;
    assign job_result    = job_result_q;
    assign job_error     = job_error_q;
    assign triple_count  = triple_count_q;

endmodule

`default_nettype wire

// File: tb/tb_function_eval_driver.sv
// ============================================================================
// Module   : tb_function_eval_driver
// Brief    : Directed self-checking bench with a behavioural evaluator.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_function_eval_driver;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        job_start = 1'b0;
    logic        s_valid = 1'b0;
    logic [31:0] s_data = 32'd0;
    logic        s_last = 1'b0;
    logic        s_ready;
    logic        job_done;
    logic [31:0] job_result;
    logic        job_error;
    logic [15:0] triple_count;

    function_eval_driver_if #(.FLT_DATA_WIDTH(32), .N_WIDTH(2)) ci_if ();

    function_eval_driver dut (
        .clk          (clk),
        .rst          (rst),
        .job_start    (job_start),
        .s_valid      (s_valid),
        .s_data       (s_data),
        .s_last       (s_last),
        .s_ready      (s_ready),
        .ci           (ci_if),
        .job_done     (job_done),
        .job_result   (job_result),
        .job_error    (job_error),
        .triple_count (triple_count)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fails  = 0;
    int          cycle    = 0;
    int          done_count = 0;
    int          done_cyc = 0;
    int          go_cyc   = 0;
    int          ev_cnt   = 0;
    logic        suppress_go = 1'b0;
    logic [31:0] eval_result = 32'd0;
    logic [31:0] log_n[$];
    logic [31:0] log_x1[$];
    logic [31:0] log_x2[$];
    logic [31:0] log_x3[$];

    assign ci_if.ci_result = eval_result;

    always @(posedge clk) cycle++;

    // Behavioural evaluator: answers each command two cycles after ci_start.
    initial ci_if.ci_done = 1'b0;
    always @(negedge clk) begin
        if (!rst) begin
            ev_cnt        = 0;
            ci_if.ci_done = 1'b0;
        end else begin
            ci_if.ci_done = 1'b0;
            if (ev_cnt > 0) begin
                ev_cnt--;
                if (ev_cnt == 0) ci_if.ci_done = 1'b1;
            end
            if (ci_if.ci_start) begin
                log_n.push_back(32'(ci_if.ci_n));
                log_x1.push_back(ci_if.ci_x_one);
                log_x2.push_back(ci_if.ci_x_two);
                log_x3.push_back(ci_if.ci_x_three);
                if (ci_if.ci_n == 2'd1) go_cyc = cycle;
                if (!(suppress_go && ci_if.ci_n == 2'd1)) ev_cnt = 2;
            end
        end
    end

    always @(negedge clk) begin
        if (rst && job_done) begin
            done_count++;
            done_cyc = cycle;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic clear_log();
        log_n.delete(); log_x1.delete(); log_x2.delete(); log_x3.delete();
    endtask

    task automatic start_job();
        @(negedge clk) job_start = 1'b1;
        @(negedge clk) job_start = 1'b0;
    endtask

    task automatic send(input logic [31:0] data, input logic last, input int gap);
        logic ok;
        repeat (gap) @(negedge clk);
        s_valid = 1'b1; s_data = data; s_last = last;
        ok = 1'b0;
        for (int i = 0; i < 300 && !ok; i++) begin
            if (s_ready) ok = 1'b1;
            @(negedge clk);
        end
        s_valid = 1'b0; s_last = 1'b0;
        if (!ok) check("sample_accept_timeout", 32'(ok), 32'd1);
    endtask

    task automatic wait_done(input string tag, input int budget);
        int start;
        start = done_count;
        for (int i = 0; i < budget && done_count == start; i++) @(negedge clk);
        check(tag, 32'(done_count != start), 32'd1);
        repeat (3) @(negedge clk);
    endtask

    task automatic send3(input int gap);
        send(32'h3F800000, 1'b0, gap);
        send(32'h40000000, 1'b0, gap);
        send(32'h40400000, 1'b1, gap);
    endtask

    int d0;

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        check("rst_s_ready",   32'(s_ready), 32'd0);
        check("rst_ci_start",  32'(ci_if.ci_start), 32'd0);
        check("rst_clk_en",    32'(ci_if.ci_clk_en), 32'd0);
        check("rst_job_done",  32'(job_done), 32'd0);
        check("rst_job_error", 32'(job_error), 32'd0);
        check("rst_ci_n",      32'(ci_if.ci_n), 32'd0);
        check("rst_x_one",     ci_if.ci_x_one, 32'd0);
        check("rst_job_result", job_result, 32'd0);
        check("rst_triple_count", 32'(triple_count), 32'd0);
        rst = 1'b1;
        repeat (2) @(negedge clk);

        // Basic job: 1.0, 2.0, 3.0
        clear_log(); eval_result = 32'h40C00000; d0 = done_count;
        start_job();
        send3(0);
        wait_done("t1_done_timeout", 300);
        check("t1_cmd_count", 32'(log_n.size()), 32'd3);
        check("t1_cmd0", log_n[0], 32'd0);
        check("t1_cmd1", log_n[1], 32'd1);
        check("t1_cmd2", log_n[2], 32'd2);
        check("t1_go_x1", log_x1[1], 32'h3F800000);
        check("t1_go_x2", log_x2[1], 32'h40000000);
        check("t1_go_x3", log_x3[1], 32'h40400000);
        check("t1_result", job_result, 32'h40C00000);
        check("t1_triples", 32'(triple_count), 32'd1);
        check("t1_done_pulses", 32'(done_count - d0), 32'd1);
        check("t1_error", 32'(job_error), 32'd0);
        check("t1_idle_clk_en", 32'(ci_if.ci_clk_en), 32'd0);

        // Five samples: second triple zero-padded
        clear_log(); eval_result = 32'h41000000;
        start_job();
        send(32'h3F800000, 1'b0, 0);
        send(32'h40000000, 1'b0, 0);
        send(32'h40400000, 1'b0, 0);
        send(32'h40800000, 1'b0, 0);
        send(32'h40A00000, 1'b1, 0);
        wait_done("t2_done_timeout", 400);
        check("t2_cmd_count", 32'(log_n.size()), 32'd4);
        check("t2_cmd2", log_n[2], 32'd1);
        check("t2_cmd3", log_n[3], 32'd2);
        check("t2_go1_x3", log_x3[1], 32'h40400000);
        check("t2_go2_x1", log_x1[2], 32'h40800000);
        check("t2_go2_x2", log_x2[2], 32'h40A00000);
        check("t2_go2_x3", log_x3[2], 32'h00000000);
        check("t2_triples", 32'(triple_count), 32'd2);
        check("t2_result", job_result, 32'h41000000);

        // Gapped stream
        clear_log(); eval_result = 32'h40C00000;
        start_job();
        send3(3);
        wait_done("t3_done_timeout", 400);
        check("t3_cmd_count", 32'(log_n.size()), 32'd3);
        check("t3_go_x1", log_x1[1], 32'h3F800000);
        check("t3_go_x2", log_x2[1], 32'h40000000);
        check("t3_go_x3", log_x3[1], 32'h40400000);
        check("t3_triples", 32'(triple_count), 32'd1);

        // job_start during FILL is ignored
        clear_log(); d0 = done_count;
        start_job();
        send(32'h3F800000, 1'b0, 0);
        start_job();
        send(32'h40000000, 1'b0, 0);
        send(32'h40400000, 1'b1, 0);
        wait_done("t4_done_timeout", 400);
        repeat (20) @(negedge clk);
        check("t4_done_pulses", 32'(done_count - d0), 32'd1);
        check("t4_cmd_count", 32'(log_n.size()), 32'd3);
        check("t4_idle_clk_en", 32'(ci_if.ci_clk_en), 32'd0);

        // Timeout on GO
        clear_log(); suppress_go = 1'b1; eval_result = 32'hDEADBEEF; d0 = done_count;
        start_job();
        send3(0);
        wait_done("t5_done_timeout", 2000);
        check("t5_error", 32'(job_error), 32'd1);
        check("t5_result_kept", job_result, 32'h40C00000);
        check("t5_timeout_latency", 32'(done_cyc - go_cyc), 32'd1025);
        check("t5_done_pulses", 32'(done_count - d0), 32'd1);
        check("t5_triples", 32'(triple_count), 32'd0);
        suppress_go = 1'b0; eval_result = 32'h40C00000;
        start_job();
        check("t5_error_cleared", 32'(job_error), 32'd0);
        send3(0);
        wait_done("t5b_done_timeout", 400);
        check("t5b_error", 32'(job_error), 32'd0);

        // Reset during GO_WAIT
        clear_log(); suppress_go = 1'b1; d0 = done_count;
        start_job();
        send3(0);
        for (int i = 0; i < 100 && log_n.size() < 2; i++) @(negedge clk);
        check("t6_go_seen", 32'(log_n.size()), 32'd2);
        repeat (5) @(negedge clk);
        rst = 1'b0;
        #1;
        check("t6_rst_clk_en", 32'(ci_if.ci_clk_en), 32'd0);
        check("t6_rst_ci_n", 32'(ci_if.ci_n), 32'd0);
        check("t6_rst_x_one", ci_if.ci_x_one, 32'd0);
        check("t6_rst_result", job_result, 32'd0);
        @(negedge clk) rst = 1'b1;
        suppress_go = 1'b0; clear_log();
        repeat (3) @(negedge clk);
        check("t6_no_abort_done", 32'(done_count - d0), 32'd0);
        start_job();
        send3(0);
        wait_done("t6_done_timeout", 400);
        check("t6_first_cmd", log_n[0], 32'd0);
        check("t6_done_pulses", 32'(done_count - d0), 32'd1);
        check("t6_result", job_result, 32'h40C00000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

`default_nettype wire
